// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop serialiser.
// Define UART_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        sys_clk,
  input  logic                        reset,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_wr,
  output logic                        tx_full,
  output logic                        tx_empty,
  output logic [$clog2(FIFO_DEPTH):0] tx_count,
  output logic                        tx_busy,
  output logic                        tx_ovf,
  output logic                        UART_TX
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt;
  logic          wr_en;
  logic          pop;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;
  logic          tx_nxt;
  logic          baud_end;

`ifdef UART_PARITY_EN
  logic par;

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  // A full FIFO rejects the write even when the FSM pops on the same edge.
  assign wr_en    = tx_wr && !tx_full;
  assign baud_end = (baud_cnt == BAUD_LAST);
  assign tx_busy  = (state != S_IDLE);

  always_comb begin
    count_nxt = tx_count;
    if (wr_en && !pop)
      count_nxt = tx_count + 1'b1;
    else if (!wr_en && pop)
      count_nxt = tx_count - 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_count <= '0;
      tx_full  <= 1'b0;
      tx_empty <= 1'b1;
      tx_ovf   <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      tx_count <= count_nxt;
      tx_full  <= (count_nxt == DEPTH_CNT);
      tx_empty <= (count_nxt == '0);
      if (tx_wr && tx_full)
        tx_ovf <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en)
      mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge sys_clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!tx_empty) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (baud_end)
          state_nxt = S_DATA;
      end
      S_DATA: begin
        if (baud_end && bit_idx == 3'd7)
`ifdef UART_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baud_end)
          state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        // Back-to-back frames: the next start bit follows the stop bit directly.
        if (baud_end) begin
          if (!tx_empty) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_nxt = UART_TX;
    case (state)
      S_IDLE:  tx_nxt = !pop;
      S_START: if (baud_end) tx_nxt = sh[0];
      S_DATA: begin
        if (baud_end) begin
          if (bit_idx == 3'd7)
`ifdef UART_PARITY_EN
            tx_nxt = par;
`else
            tx_nxt = 1'b1;
`endif
          else
            tx_nxt = sh[bit_idx + 3'd1];
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (baud_end) tx_nxt = 1'b1;
`endif
      S_STOP:  if (baud_end) tx_nxt = !pop;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      UART_TX  <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
    end else begin
      UART_TX <= tx_nxt;
      if (state == S_IDLE || baud_end)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;
      if (state == S_START && baud_end)
        bit_idx <= 3'd0;
      else if (state == S_DATA && baud_end)
        bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (pop) begin
      sh <= mem[rd_ptr];
`ifdef UART_PARITY_EN
      par <= even_par(mem[rd_ptr]);
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, directed frame sequences and random traffic
// against a queue/frame-timer reference model plus a mid-bit line decoder.
module tb_uart_tx_fifo;
  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int DEPTH    = 8;
  localparam int BD       = CLK_FREQ / BAUD;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BD;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       tx_wr   = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_full, tx_empty, tx_busy, tx_ovf, UART_TX;
  logic [3:0] tx_count;

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .reset(reset), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_count(tx_count),
    .tx_busy(tx_busy), .tx_ovf(tx_ovf), .UART_TX(UART_TX)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO as a queue, current frame as a countdown of remaining cycles.
  logic [7:0] mq[$];
  logic [7:0] m_sent[$];
  int         m_left = 0;
  logic [7:0] m_cur = 8'h00;
  logic       m_ovf = 1'b0;

  // Line decoder state.
  logic [7:0]       dec_q[$];
  bit               dec_on = 1'b0;
  int               dec_ph = 0;
  logic [NBITS-1:0] dec_bits = '0;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] d;
    logic       tx;
    logic [3:0] cnt;
    logic       busy;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_line();
    int pos;
    if (m_left == 0) return 1'b1;
    pos = (FRAME - m_left) / BD;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return m_cur[pos-1];
`ifdef UART_PARITY_EN
    if (pos == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  task automatic decode();
    int idx;
    if (!dec_on) begin
      if (UART_TX === 1'b0) begin
        dec_on = 1'b1;
        dec_ph = 0;
      end
    end else begin
      dec_ph++;
      if (dec_ph % BD == BD / 2) begin
        idx = dec_ph / BD;
        dec_bits[idx] = UART_TX;
        if (idx == NBITS - 1) begin
          chk("start_bit", 32'(dec_bits[0]), 32'd0);
          chk("stop_bit", 32'(dec_bits[NBITS-1]), 32'd1);
`ifdef UART_PARITY_EN
          chk("parity_bit", 32'(dec_bits[9]), 32'(^dec_bits[8:1]));
`endif
          dec_q.push_back(dec_bits[8:1]);
          dec_on = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic wr, input logic [7:0] d);
    bit do_pop;
    bit do_wr;
    reset   = rst;
    tx_wr   = wr;
    tx_data = d;
    @(posedge sys_clk);
    if (rst) begin
      mq.delete();
      m_sent.delete();
      dec_q.delete();
      m_left = 0;
      m_ovf  = 1'b0;
      dec_on = 1'b0;
    end else begin
      do_pop = (mq.size() > 0) && (m_left <= 1);
      do_wr  = wr && (mq.size() < DEPTH);
      if (wr && !do_wr) m_ovf = 1'b1;
      if (do_pop) begin
        m_cur  = mq.pop_front();
        m_sent.push_back(m_cur);
        m_left = FRAME;
      end else if (m_left > 0) begin
        m_left--;
      end
      if (do_wr) mq.push_back(d);
    end
    #1;
    chk("uart_tx", 32'(UART_TX), 32'(m_line()));
    chk("count_busy_full_empty_ovf",
        32'({tx_count, tx_busy, tx_full, tx_empty, tx_ovf}),
        32'({4'(mq.size()), m_left > 0, mq.size() == DEPTH, mq.size() == 0, m_ovf}));
    if (!rst) decode();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_dec(input logic [7:0] exp[$]);
    chk("decoded_count", 32'(dec_q.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < dec_q.size())
        chk("decoded_byte", 32'(dec_q[i]), 32'(exp[i]));
      else
        chk("decoded_byte_missing", 32'hFFFF_FFFF, 32'(exp[i]));
    end
    dec_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] eq[$];
    int cyc;
    bit found;

    // rst, wr, d, tx, cnt, busy, full, empty, ovf
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 8'hEE, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'h55, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].d);
      chk($sformatf("vec%0d", i),
          32'({UART_TX, tx_count, tx_busy, tx_full, tx_empty, tx_ovf}),
          32'({tbl[i].tx, tbl[i].cnt, tbl[i].busy, tbl[i].full, tbl[i].empty, tbl[i].ovf}));
    end

    // 0x55 frame: busy lasts one full frame from the falling edge.
    cyc = 1;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 1'b0, 8'h00);
      cyc++;
      if (!tx_busy) begin
        found = 1'b1;
        break;
      end
    end
    chk("busy_found", 32'(found), 32'd1);
    chk("frame_len", 32'(cyc), 32'(FRAME));
    idle(4);
    eq = {8'h55};
    check_dec(eq);

    // Two back-to-back frames.
    step(1'b0, 1'b1, 8'hA3);
    chk("cnt_after_a3", 32'(tx_count), 32'd1);
    step(1'b0, 1'b1, 8'h0F);
    chk("cnt_after_0f", 32'(tx_count), 32'd1);
    idle(2 * FRAME + 10);
    eq = {8'hA3, 8'h0F};
    check_dec(eq);

    // Overflow: ten writes, one pops immediately, the tenth is dropped.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'(i));
      if (i == 8) chk("full_after_9th", 32'(tx_full), 32'd1);
    end
    chk("ovf_set", 32'(tx_ovf), 32'd1);
    chk("cnt_full", 32'(tx_count), 32'd8);
    idle(9 * FRAME + 20);
    eq = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    check_dec(eq);

    // Reset 50 cycles into a frame with three bytes queued.
    step(1'b1, 1'b0, 8'h00);
    chk("ovf_cleared", 32'(tx_ovf), 32'd0);
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h03);
    idle(47);
    step(1'b1, 1'b0, 8'h00);
    chk("abort_line_cnt_busy", 32'({UART_TX, tx_count, tx_busy}), 32'({1'b1, 4'd0, 1'b0}));
    idle(3 * FRAME);
    eq = {};
    check_dec(eq);

    // Write on the STOP->START pop edge with three entries queued.
    step(1'b0, 1'b1, 8'h10);
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h12);
    step(1'b0, 1'b1, 8'h13);
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_left == 1) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 8'h00);
    end
    chk("stop_end_reached", 32'(found), 32'd1);
    chk("cnt_before_pop", 32'(tx_count), 32'd3);
    step(1'b0, 1'b1, 8'h14);
    chk("cnt_pop_and_write", 32'(tx_count), 32'd3);
    idle(5 * FRAME + 20);
    eq = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    check_dec(eq);

`ifdef UART_PARITY_EN
    step(1'b0, 1'b1, 8'h07);
    step(1'b0, 1'b1, 8'h03);
    idle(2 * FRAME + 20);
    eq = {8'h07, 8'h03};
    check_dec(eq);
`endif

    // Random traffic: heavy then light write rate, with rare resets.
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4000; i++) begin
      logic rr;
      logic ww;
      rr = ($urandom_range(0, 999) == 0);
      ww = (i < 2000) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 2);
      step(rr, ww, 8'($urandom));
    end
    idle((DEPTH + 1) * FRAME + 20);
    check_dec(m_sent);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
